seg7_scanner: RTL

Multiplexed seven-segment display driver fed by the divided clock from `clk_divider`. It samples the slow `scan_clk` as data in the fast `clk_in` domain and advances one digit per rising edge of `scan_clk`. It shows a frame-latched hexadecimal word (the CPU's debug or result bus) on a common-anode display, with optional leading-zero blanking and per-digit decimal points.

---
 rtl/seg7_scanner.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seg7_scanner.sv
// seg7_scanner: multiplexed common-anode seven-segment driver with frame-latched data.
// Latency: scan_clk rise sampled at edge k -> idx moves at k+2 -> an/seg/dp show it at k+3.
// Backpressure: none; scan_clk is a free-running pacing input and data is sampled once per frame.
//
// Ports:
//   clk_in      system clock (only clock of the block)
//   reset       synchronous, active-high
//   scan_clk    divided clock, sampled as data; one digit advance per rising edge
//   data        4*DIGITS-bit value; nibble i drives digit i (digit 0 rightmost)
//   dp_mask     bit i lights decimal point of digit i
//   blank_lz    enables leading-zero blanking
//   hold        freezes the displayed frame (sampled only at frame wrap)
//   an          active-low one-hot digit enables
//   seg         active-low segments {g,f,e,d,c,b,a}
//   dp          active-low decimal point
//   frame_done  one-cycle pulse after each frame wrap
module seg7_scanner #(
  parameter int DIGITS = 8
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  scan_clk,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  input  logic                  hold,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  logic                s1, s2, s3;
  logic                tick;
  logic                wrap;
  logic [IW-1:0]       idx;

  // Frame shadows: the outputs only ever read these, so a frame cannot tear.
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic                sh_blz;

  logic [DIGITS-1:0]   an_nxt;
  logic [6:0]          seg_nxt;
  logic [3:0]          nib;
  logic                dp_sel;
  logic                upper_zero;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // s2/s3 are both post-synchroniser, so the edge detect sees a clean level.
  assign tick = s2 & ~s3;
  assign wrap = tick && (idx == LAST_IDX);

  always_comb begin
    nib        = 4'h0;
    dp_sel     = 1'b0;
    upper_zero = 1'b1;
    an_nxt     = '1;
    for (int j = 0; j < DIGITS; j++) begin
      if (idx == IW'(j)) begin
        nib       = sh_data[4*j +: 4];
        dp_sel    = sh_dp[j];
        an_nxt[j] = 1'b0;
      end
      // Blank only if this digit and every more-significant digit is zero.
      if ((IW'(j) >= idx) && (sh_data[4*j +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    // Digit 0 is never blanked so a zero value still shows "0".
    if (sh_blz && (idx != '0) && upper_zero) begin
      seg_nxt = 7'h7F;
    end else begin
      seg_nxt = hex7(nib);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      idx        <= '0;
      sh_data    <= '0;
      sh_dp      <= '0;
      sh_blz     <= 1'b0;
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      s1 <= scan_clk;
      s2 <= s1;
      s3 <= s2;
      if (tick) begin
        idx <= wrap ? '0 : idx + IW'(1);
      end
      frame_done <= wrap;
      if (wrap && !hold) begin
        sh_data <= data;
        sh_dp   <= dp_mask;
        sh_blz  <= blank_lz;
      end
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= ~dp_sel;
    end
  end

endmodule
